// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - ALU/load writeback arbiter with ALU FIFO, x0 drop and same-rd load hazard stall
module writeback_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_rd,
    input  logic [31:0]              mem_data,
    output logic                     reg_write,
    output logic [4:0]               write_reg,
    output logic [31:0]              write_data,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [4:0]       q_rd   [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;

    logic full;
    logic empty;
    logic hazard;
    logic mem_acc;
    logic alu_acc;
    logic issue_mem;
    logic issue_head;
    logic issue_bypass;
    logic enq;
    logic deq;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // A load stalls while any queued ALU write targets the same non-zero rd,
    // so the older ALU value can never land after the newer load value.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && (q_rd[i] == mem_rd)) begin
                hazard = 1'b1;
            end
        end
    end

    assign alu_ready = !reset && !full;
    assign mem_ready = !reset && !((mem_rd != 5'd0) && hazard);

    // Writes to x0 are accepted by the handshake but never enter the issue path.
    assign mem_acc      = mem_valid && mem_ready && (mem_rd != 5'd0);
    assign alu_acc      = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign issue_mem    = mem_acc;
    assign issue_head   = !mem_acc && !empty;
    assign issue_bypass = !mem_acc && empty && alu_acc;
    assign enq          = alu_acc && !issue_bypass;
    assign deq          = issue_head;

    assign pending = count;

    // Queue bookkeeping and the registered register-file write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_vld      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            reg_write  <= 1'b0;
            write_reg  <= 5'd0;
            write_data <= 32'd0;
        end else begin
            if (enq) begin
                q_rd[wr_ptr]   <= alu_rd;
                q_data[wr_ptr] <= alu_data;
                q_vld[wr_ptr]  <= 1'b1;
                wr_ptr         <= wr_ptr + PTR_ONE;
            end
            if (deq) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_ONE;
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            reg_write <= issue_mem || issue_head || issue_bypass;
            if (issue_mem) begin
                write_reg  <= mem_rd;
                write_data <= mem_data;
            end else if (issue_head) begin
                write_reg  <= q_rd[rd_ptr];
                write_data <= q_data[rd_ptr];
            end else if (issue_bypass) begin
                write_reg  <= alu_rd;
                write_data <= alu_data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - scoreboard bench for writeback_arbiter
module tb_writeback_arbiter;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [2:0]  pending;

    int checks = 0;
    int failures = 0;
    wr_t sb[$];
    wr_t mon_e;
    logic [31:0] last_val [32];

    writeback_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data), .pending(pending)
    );

    always #5 clk = ~clk;

    // Every register-file write must match the next expected write.
    always @(negedge clk) begin
        if (reg_write === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got rd=%0d data=%h expected no write", write_reg, write_data);
            end else begin
                mon_e = sb.pop_front();
                if (write_reg !== mon_e.rd || write_data !== mon_e.data) begin
                    failures++;
                    $display("FAIL sb_write got rd=%0d data=%h expected rd=%0d data=%h",
                             write_reg, write_data, mon_e.rd, mon_e.data);
                end
            end
            last_val[write_reg] = write_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int rd, input logic [31:0] data);
        wr_t e;
        e.rd = 5'(rd);
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got %0d writes outstanding expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        step();
        step();
        checks++;
        if ({reg_write, write_reg, write_data, pending, alu_ready, mem_ready} !== 42'd0) begin
            failures++;
            $display("FAIL reset_state got we=%b rd=%0d data=%h pend=%0d ar=%b mr=%b expected all 0",
                     reg_write, write_reg, write_data, pending, alu_ready, mem_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_ready got ar=%b mr=%b expected 1 1", alu_ready, mem_ready);
        end
    endtask

    task automatic test_bypass();
        step();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
        push(5, 32'h1234_5678);
        step();
        alu_valid = 1'b0;
        checks++;
        if (reg_write !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'h1234_5678 || pending !== 3'd0) begin
            failures++;
            $display("FAIL bypass got we=%b rd=%0d data=%h pend=%0d expected 1 5 12345678 0",
                     reg_write, write_reg, write_data, pending);
        end
        drain("bypass");
    endtask

    task automatic test_x0();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            failures++;
            $display("FAIL x0_accept got ar=%b mr=%b expected 1 1", alu_ready, mem_ready);
        end
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (reg_write !== 1'b0 || pending !== 3'd0) begin
                failures++;
                $display("FAIL x0_drop cycle %0d got we=%b pend=%0d expected 0 0", i, reg_write, pending);
            end
            step();
        end
    endtask

    task automatic test_priority();
        mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'hAAAA_0001;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hBBBB_0002;
        push(1, 32'hAAAA_0001);
        push(2, 32'hBBBB_0002);
        step();
        mem_valid = 1'b0; alu_valid = 1'b0;
        checks++;
        if (reg_write !== 1'b1 || write_reg !== 5'd1 || pending !== 3'd1) begin
            failures++;
            $display("FAIL prio_first got we=%b rd=%0d pend=%0d expected 1 1 1", reg_write, write_reg, pending);
        end
        step();
        checks++;
        if (reg_write !== 1'b1 || write_reg !== 5'd2 || pending !== 3'd0) begin
            failures++;
            $display("FAIL prio_second got we=%b rd=%0d pend=%0d expected 1 2 0", reg_write, write_reg, pending);
        end
        drain("prio");
    endtask

    task automatic test_full();
        wr_t hold[$];
        wr_t e;
        int a = 0;
        int m = 0;
        int cyc = 0;
        bit saw_full = 1'b0;
        while (a < 5 && cyc < 30) begin
            mem_valid = (m < 6);
            if (mem_valid) begin
                mem_rd = 5'(20 + m);
                mem_data = 32'hD000_0000 + 32'(m);
                push(20 + m, mem_data);
                m++;
            end
            alu_valid = 1'b1;
            alu_rd = 5'(3 + a);
            alu_data = 32'hC000_0000 + 32'(a);
            #1;
            if (alu_ready) begin
                e.rd = alu_rd;
                e.data = alu_data;
                hold.push_back(e);
                a++;
            end else begin
                saw_full = 1'b1;
                checks++;
                if (pending !== 3'd4) begin
                    failures++;
                    $display("FAIL full_pending got pend=%0d with alu_ready=0 expected 4", pending);
                end
            end
            if (!mem_valid) begin
                while (hold.size() != 0) sb.push_back(hold.pop_front());
            end
            step();
            cyc++;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        while (hold.size() != 0) sb.push_back(hold.pop_front());
        checks++;
        if (saw_full !== 1'b1 || a != 5) begin
            failures++;
            $display("FAIL full_seen got saw_full=%b accepted=%0d expected 1 5", saw_full, a);
        end
        drain("full");
    endtask

    task automatic test_hazard();
        int n = 0;
        int stalls = 0;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'h0000_0010;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0011;
        push(10, 32'h0000_0010);
        step();
        alu_valid = 1'b0;
        mem_rd = 5'd9; mem_data = 32'h0000_0022;
        push(9, 32'h0000_0011);
        #1;
        checks++;
        if (mem_ready !== 1'b0) begin
            failures++;
            $display("FAIL hazard_stall got mem_ready=%b expected 0", mem_ready);
        end
        while (mem_ready !== 1'b1 && n < 10) begin
            stalls++;
            step();
            n++;
        end
        checks++;
        if (mem_ready !== 1'b1) begin
            failures++;
            $display("FAIL hazard_release got mem_ready=%b expected 1 within 10 cycles", mem_ready);
        end
        push(9, 32'h0000_0022);
        step();
        mem_valid = 1'b0;
        drain("hazard");
        checks++;
        if (last_val[9] !== 32'h0000_0022) begin
            failures++;
            $display("FAIL hazard_final got x9=%h expected 00000022", last_val[9]);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_rd = 5'(11 + i); mem_data = 32'hE000_0000 + 32'(i);
            alu_valid = 1'b1; alu_rd = 5'(14 + i); alu_data = 32'hF000_0000 + 32'(i);
            push(11 + i, mem_data);
            step();
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        checks++;
        if (pending !== 3'd3) begin
            failures++;
            $display("FAIL midreset_pre got pend=%0d expected 3", pending);
        end
        #2;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (pending !== 3'd0 || reg_write !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear got pend=%0d we=%b expected 0 0", pending, reg_write);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (reg_write !== 1'b0) begin
                failures++;
                $display("FAIL midreset_quiet cycle %0d got we=%b expected 0", i, reg_write);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL midreset_sb got %0d outstanding expected 0", sb.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) last_val[i] = 32'd0;
        test_reset();
        test_bypass();
        test_x0();
        test_priority();
        test_full();
        test_hazard();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the ALU writeback queue depth (power of two, minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port alu_valid, input, 1 bit: ALU result request.
REQ-005 The block SHALL have port alu_ready, output, 1 bit: the ALU request is accepted this cycle.
REQ-006 The block SHALL have port alu_rd, input, 5 bits: ALU destination register.
REQ-007 The block SHALL have port alu_data, input, 32 bits: ALU result.
REQ-008 The block SHALL have port mem_valid, input, 1 bit: load result request.
REQ-009 The block SHALL have port mem_ready, output, 1 bit: the load request is accepted this cycle.
REQ-010 The block SHALL have port mem_rd, input, 5 bits: load destination register.
REQ-011 The block SHALL have port mem_data, input, 32 bits: load data.
REQ-012 The block SHALL have port reg_write, output, 1 bit: register file write enable (registered).
REQ-013 The block SHALL have port write_reg, output, 5 bits: register file write address (registered).
REQ-014 The block SHALL have port write_data, output, 32 bits: register file write data (registered).
REQ-015 The block SHALL have port pending, output, clog2(DEPTH)+1 bits: current ALU queue occupancy.

Function
REQ-016 A request SHALL be accepted when its valid and ready are both high at a rising clk edge.
REQ-017 The block SHALL drive alu_ready = !full, with full computed from registered occupancy only, so that no enqueue occurs when full even if a dequeue happens in the same cycle.
REQ-018 The block SHALL drive mem_ready = 1 unless mem_rd != 0 and some queued entry has rd == mem_rd; in that case mem_ready = 0 until the queue no longer holds that rd.
REQ-019 The block SHALL accept, but never store or issue, requests with rd = 0, so that x0 is never written.
REQ-020 The block SHALL issue at most one register file write per cycle, selecting by priority as follows:
- first, an accepted load;
- else, the queue head, when the queue is non-empty;
- else, an accepted ALU request directly (bypass; not enqueued).
REQ-021 The block SHALL enqueue an accepted ALU request (rd != 0) whenever the request is not issued that cycle.
REQ-022 The block SHALL register the issued write: reg_write/write_reg/write_data SHALL be valid exactly one cycle after acceptance (bypass or load) or after dequeue.
REQ-023 The block SHALL drive reg_write = 0, and hold write_reg/write_data at their previous values, in any cycle with no issue.
REQ-024 The block SHALL issue writes to the same rd from the same port in acceptance order; the queue is strict FIFO.
REQ-025 On a simultaneous enqueue and dequeue, pending SHALL remain unchanged and the head pointer SHALL advance.
REQ-026 The read/write pointers SHALL wrap modulo DEPTH, and full/empty SHALL be decided by occupancy, not by pointer equality alone.
REQ-027 pending SHALL equal the registered occupancy: 0..DEPTH, updated on the edge.

Reset
REQ-028 While reset is high, the block SHALL drive reg_write = 0, write_reg = 0, write_data = 0, pending = 0, queue empty, pointers 0, alu_ready = 0, mem_ready = 0.
REQ-029 The block SHALL discard any accepted-but-unissued entries when reset asserts mid-operation; none SHALL be issued after reset.
REQ-030 In the first cycle after reset deasserts, the block SHALL drive alu_ready = 1 and mem_ready = 1.

Verification
REQ-031 The bench SHALL cover bypass: idle, alu_valid, alu_rd = 5, alu_data = 0x12345678 -> next cycle reg_write = 1, write_reg = 5, write_data = 0x12345678; pending stays 0.
REQ-032 The bench SHALL cover x0 drop: alu rd = 0, data = 0xDEADBEEF, and mem rd = 0 -> both accepted, reg_write stays 0 for 3 cycles.
REQ-033 The bench SHALL cover priority/queueing: mem (rd = 1, data = 0xAAAA0001) and ALU (rd = 2, data = 0xBBBB0002) in the same cycle -> cycle+1 writes x1, cycle+2 writes x2; pending is 1 then 0.
REQ-034 The bench SHALL cover full: hold mem_valid with distinct rds while sending 5 ALU requests (rd 3..7) with DEPTH = 4 -> alu_ready = 0 when pending = 4; after mem_valid drops, rds 3,4,5,6,7 are issued in order.
REQ-035 The bench SHALL cover the same-rd hazard: queue holds rd = 9 (0x11), then mem rd = 9 (0x22) -> mem_ready = 0 until the 0x11 write is issued; the final value written last to x9 is 0x22.
REQ-036 The bench SHALL cover reset mid-operation: pending = 3, assert reset for 1 cycle -> pending = 0, and no reg_write afterwards without new requests.
